// File: rtl/acu_pkg.sv
// Shared constants and FSM state type for the
// running-sum differencer.
package acu_pkg;

  localparam int ACU_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } acu_state_t;

endpackage

// File: rtl/acu_diff_rsub.sv
// W-bit ripple subtractor built from full-subtractor
// cells; bout is set when x < y (unsigned).
module rsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] b;

  // ripple the borrow from lsb to msb
  always_comb begin
    b[0] = 1'b0;
    d    = '0;
    for (int i = 0; i < W; i++) begin
      d[i]   = x[i] ^ y[i] ^ b[i];
      b[i+1] = (~x[i] & y[i]) |
               (~(x[i] ^ y[i]) & b[i]);
    end
  end

  assign bout = b[W];

endmodule

// File: rtl/acu_diff.sv
// Recovers increments from a modulo-2^W running sum.
// Define ACU_DIFF_CNT_EN to add the saturating cnt port.
module acu_diff
  import acu_pkg::*;
#(
  parameter int W = ACU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] s,
  output logic         out_valid,
  output logic [W-1:0] a,
  output logic         borrow,
  output logic         first
`ifdef ACU_DIFF_CNT_EN
  ,
  output logic [W-1:0] cnt
`endif
);

  acu_state_t state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] a_q, a_d;
  logic         borrow_q, borrow_d;
  logic         first_q, first_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] prev_eff;
  logic [W-1:0] diff;
  logic         bout;

  // clr restarts the stream, so a same-cycle sample sees prev=0
  assign prev_eff = clr ? '0 : prev_q;

  rsub #(.W(W)) u_rsub (
    .x    (s),
    .y    (prev_eff),
    .d    (diff),
    .bout (bout)
  );

`ifdef ACU_DIFF_CNT_EN
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_base;

  assign cnt_base = clr ? '0 : cnt_q;

  // saturating accept counter
  always_comb begin
    cnt_d = cnt_base;
    if (in_valid && (cnt_base != '1))
      cnt_d = cnt_base + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

  // next-state for history, fsm and held outputs
  always_comb begin
    state_d     = clr ? EMPTY : state_q;
    prev_d      = prev_eff;
    a_d         = a_q;
    borrow_d    = borrow_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      a_d         = diff;
      borrow_d    = bout;
      first_d     = clr || (state_q == EMPTY);
      prev_d      = s;
      state_d     = RUN;
      out_valid_d = 1'b1;
    end
  end

  // fsm, history and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      a_q         <= '0;
      borrow_q    <= 1'b0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      a_q         <= a_d;
      borrow_q    <= borrow_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign borrow    = borrow_q;
  assign first     = first_q;

endmodule

// File: doc/acu_diff.md
ACU_DIFF -- requirements
Module: acu_diff

Interface
REQ-001 Parameter: W, default 8, datapath width of sum input and recovered output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clr  input  1  synchronous stream restart; history is zeroed.
REQ-005 in_valid  input  1  s is a valid running-sum sample this cycle.
REQ-006 s  input  W  running sum, modulo 2^W, produced by the accumulator.
REQ-007 out_valid  output  1  a/borrow/first are valid this cycle.
REQ-008 a  output  W  recovered increment, s[n] - s[n-1] mod 2^W.
REQ-009 borrow  output  1  set when s[n] < s[n-1] (unsigned), i.e. the sum wrapped.
REQ-010 first  output  1  marks the first recovered sample after reset or clr.
REQ-011 cnt  output  W  saturating count of accepted samples (only with ACU_DIFF_CNT_EN).

Function
REQ-012 The block SHALL hold prev (W bits) and a two-state FSM: EMPTY (no sample since reset/clr), RUN.
REQ-013 Accept: a sample is accepted on any rising edge with in_valid=1 and rst=0.
REQ-014 On accept: a <= s - prev (mod 2^W); borrow <= (s < prev); prev <= s; out_valid <= 1; first <= (state==EMPTY); state <= RUN.
REQ-015 Latency SHALL be exactly 1 cycle from an accepted s to its out_valid/a.
REQ-016 No accept: out_valid <= 0; a, borrow, first SHALL hold their last values; prev and state unchanged.
REQ-017 In EMPTY prev SHALL be 0, so the first recovered a equals s (matches an accumulator whose register resets to 0).
REQ-018 Back-to-back in_valid SHALL be accepted every cycle with no bubbles; no backpressure exists.
REQ-019 clr without in_valid: prev <= 0; state <= EMPTY; out_valid <= 0; cnt <= 0.
REQ-020 clr with in_valid same cycle: the sample SHALL be decoded against prev=0, first <= 1, prev <= s, state <= RUN, cnt <= 1.
REQ-021 Wrap-around: subtraction SHALL be modulo 2^W; no saturation of a.

Reset
REQ-022 On rst=1 at a rising edge: prev=0, state=EMPTY, out_valid=0, a=0, borrow=0, first=0, cnt=0.
REQ-023 rst SHALL override clr and in_valid; a sample presented during reset SHALL be dropped.
REQ-024 Reset mid-stream SHALL leave no residue: the next accepted sample is treated as first.

Configuration
REQ-025 Macro ACU_DIFF_CNT_EN defined: cnt port and counter SHALL exist; counter increments on each accept, saturates at 2^W-1, cleared by rst/clr.
REQ-026 Macro ACU_DIFF_CNT_EN undefined: cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package acu_pkg SHALL hold the default width constant and the FSM state type (EMPTY, RUN).
REQ-028 Subtraction SHALL be a separate sub-module rsub (W-bit ripple subtractor of full-subtractor cells, borrow-out = borrow flag).
REQ-029 All other logic (prev register, FSM, output register, counter) SHALL reside in acu_diff.

Verification
REQ-030 Reset, then s=3,8,8 on consecutive in_valid cycles -> a=3(first=1),5,0; borrow=0 throughout; cnt=3.
REQ-031 prev=250, in_valid with s=4 -> a=10, borrow=1, first=0.
REQ-032 in_valid gaps: s=10, idle 2 cycles, s=15 -> out_valid pulses only 1 cycle after each accept; a=10 held during gap, then a=5.
REQ-033 prev=100, clr+in_valid with s=40 -> a=40, first=1, borrow=0, cnt=1; next s=50 -> a=10.
REQ-034 rst asserted while in_valid=1, s=77 -> all outputs 0 next cycle; following s=77 -> a=77, first=1.
REQ-035 Closed loop: random a stream through accumulator, then acu_diff -> recovered a equals original a every cycle for 1000 samples; with ACU_DIFF_CNT_EN cnt saturates at 255.
